// File: rtl/mcu_stream_pairer.sv
// Pairs each data/scale sample with every grid point of its row and emits
// aligned {scale, grid, data} beats; optional skid output via MCU_PAIR_SKID_EN.
//
// Ports: clk, rst_n (async active-low), cfg_grid_len, err_clear,
//   s_axis_data_* / s_axis_grid_* / s_axis_scle_* (inputs),
//   m_axis_* (packed output), rows_done, busy, err_grid_len.
module mcu_stream_pairer #(
  parameter int DATA_WIDTH_DATA  = 16,
  parameter int DATA_WIDTH_SCALE = 16,
  parameter int GRID_CNT_WIDTH   = 8,
  parameter int ROW_CNT_WIDTH    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [GRID_CNT_WIDTH-1:0]  cfg_grid_len,
  input  logic                       err_clear,
  input  logic [DATA_WIDTH_DATA-1:0] s_axis_data_tdata,
  input  logic                       s_axis_data_tvalid,
  output logic                       s_axis_data_tready,
  input  logic                       s_axis_data_tlast,
  input  logic [DATA_WIDTH_DATA-1:0] s_axis_grid_tdata,
  input  logic                       s_axis_grid_tvalid,
  output logic                       s_axis_grid_tready,
  input  logic                       s_axis_grid_tlast,
  input  logic [DATA_WIDTH_SCALE-1:0] s_axis_scle_tdata,
  input  logic                       s_axis_scle_tvalid,
  output logic                       s_axis_scle_tready,
  output logic [DATA_WIDTH_SCALE+2*DATA_WIDTH_DATA-1:0] m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [ROW_CNT_WIDTH-1:0]   rows_done,
  output logic                       busy,
  output logic                       err_grid_len
);

  localparam int OW = DATA_WIDTH_SCALE + 2 * DATA_WIDTH_DATA;

  localparam logic [0:0] LOAD = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]                  state;
  logic [0:0]                  state_nxt;
  logic [DATA_WIDTH_DATA-1:0]  data_reg;
  logic [DATA_WIDTH_SCALE-1:0] scale_reg;
  logic                        data_last_reg;
  logic [GRID_CNT_WIDTH-1:0]   len_reg;
  logic [GRID_CNT_WIDTH-1:0]   grid_cnt;
  logic [GRID_CNT_WIDTH-1:0]   cnt_inc;

  logic          ld_fire;
  logic          grid_fire;
  logic          cnt_hit;
  logic          row_end;
  logic          err_set;
  logic          pop;
  logic [OW-1:0] beat;
  logic          beat_last;

  // Data and scale only move together, and never while reset is held.
  assign ld_fire = rst_n && (state == LOAD) &&
                   s_axis_data_tvalid && s_axis_scle_tvalid;
  assign s_axis_data_tready = ld_fire;
  assign s_axis_scle_tready = ld_fire;

  assign grid_fire = s_axis_grid_tvalid && s_axis_grid_tready;
  assign cnt_inc   = grid_cnt + 1'b1;
  assign cnt_hit   = (cnt_inc == len_reg);
  // A row ends on tlast or on reaching the configured length;
  // an error is exactly one of the two happening without the other.
  assign row_end   = grid_fire && (s_axis_grid_tlast || cnt_hit);
  assign err_set   = grid_fire && (s_axis_grid_tlast != cnt_hit);
  assign beat      = {scale_reg, s_axis_grid_tdata, data_reg};
  assign beat_last = s_axis_grid_tlast && data_last_reg;
  assign pop       = m_axis_tvalid && m_axis_tready;

  assign busy = (state == RUN) || m_axis_tvalid;

  always_comb begin
    state_nxt = state;
    if (ld_fire)      state_nxt = RUN;
    else if (row_end) state_nxt = LOAD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= LOAD;
      data_reg      <= '0;
      scale_reg     <= '0;
      data_last_reg <= 1'b0;
      len_reg       <= '0;
      grid_cnt      <= '0;
      rows_done     <= '0;
      err_grid_len  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ld_fire) begin
        data_reg      <= s_axis_data_tdata;
        scale_reg     <= s_axis_scle_tdata;
        data_last_reg <= s_axis_data_tlast;
        len_reg       <= cfg_grid_len;
        grid_cnt      <= '0;
      end else if (grid_fire) begin
        grid_cnt <= cnt_inc;
      end
      if (row_end) rows_done <= rows_done + 1'b1;
      if (err_set)        err_grid_len <= 1'b1;
      else if (err_clear) err_grid_len <= 1'b0;
    end
  end

`ifdef MCU_PAIR_SKID_EN

  logic [OW:0] ent0;
  logic [OW:0] ent1;
  logic [1:0]  fill;
  logic [1:0]  fill_nxt;
  logic        rdy_q;

  always_comb begin
    fill_nxt = fill;
    if (grid_fire && !pop)      fill_nxt = fill + 2'd1;
    else if (!grid_fire && pop) fill_nxt = fill - 2'd1;
  end

  // Registered ready: looks only at next-cycle occupancy and state.
  assign s_axis_grid_tready = rdy_q;
  assign m_axis_tvalid      = (fill != 2'd0);
  assign m_axis_tdata       = ent0[OW-1:0];
  assign m_axis_tlast       = ent0[OW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0  <= '0;
      ent1  <= '0;
      fill  <= 2'd0;
      rdy_q <= 1'b0;
    end else begin
      fill  <= fill_nxt;
      rdy_q <= (state_nxt == RUN) && (fill_nxt != 2'd2);
      if (grid_fire && ((fill == 2'd0) || ((fill == 2'd1) && pop)))
        ent0 <= {beat_last, beat};
      else if (pop)
        ent0 <= ent1;
      if (grid_fire && (((fill == 2'd1) && !pop) || ((fill == 2'd2) && pop)))
        ent1 <= {beat_last, beat};
    end
  end

`else

  assign s_axis_grid_tready = rst_n && (state == RUN) &&
                              (!m_axis_tvalid || m_axis_tready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (grid_fire) begin
      m_axis_tdata  <= beat;
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= beat_last;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_mcu_stream_pairer.sv
// Directed self-checking bench for mcu_stream_pairer.
// Beats are collected at the falling edge and compared to hand-built lists.
module tb_mcu_stream_pairer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  cfg_grid_len = 8'd4;
  logic        err_clear = 1'b0;
  logic [15:0] data_tdata = '0;
  logic        data_tvalid = 1'b0;
  logic        data_tready;
  logic        data_tlast = 1'b0;
  logic [15:0] grid_tdata = '0;
  logic        grid_tvalid = 1'b0;
  logic        grid_tready;
  logic        grid_tlast = 1'b0;
  logic [15:0] scle_tdata = '0;
  logic        scle_tvalid = 1'b0;
  logic        scle_tready;
  logic [47:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        m_tlast;
  logic [15:0] rows_done;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [48:0] q_beat[$];
  int          q_cyc[$];
  logic [48:0] exp_q[$];

  mcu_stream_pairer dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .cfg_grid_len       (cfg_grid_len),
    .err_clear          (err_clear),
    .s_axis_data_tdata  (data_tdata),
    .s_axis_data_tvalid (data_tvalid),
    .s_axis_data_tready (data_tready),
    .s_axis_data_tlast  (data_tlast),
    .s_axis_grid_tdata  (grid_tdata),
    .s_axis_grid_tvalid (grid_tvalid),
    .s_axis_grid_tready (grid_tready),
    .s_axis_grid_tlast  (grid_tlast),
    .s_axis_scle_tdata  (scle_tdata),
    .s_axis_scle_tvalid (scle_tvalid),
    .s_axis_scle_tready (scle_tready),
    .m_axis_tdata       (m_tdata),
    .m_axis_tvalid      (m_tvalid),
    .m_axis_tready      (m_tready),
    .m_axis_tlast       (m_tlast),
    .rows_done          (rows_done),
    .busy               (busy),
    .err_grid_len       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && m_tvalid && m_tready) begin
      q_beat.push_back({m_tlast, m_tdata});
      q_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [48:0] bt(input logic l, input logic [15:0] s,
                                     input logic [15:0] g,
                                     input logic [15:0] d);
    return {l, s, g, d};
  endfunction

  task automatic start_test();
    q_beat.delete();
    q_cyc.delete();
    exp_q.delete();
  endtask

  task automatic send_ds(input logic [15:0] d, input logic dl,
                         input logic [15:0] s);
    int n;
    n = 0;
    data_tdata  = d;
    data_tlast  = dl;
    scle_tdata  = s;
    data_tvalid = 1'b1;
    scle_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (data_tready) break;
      n++;
      if (n > 200) begin
        chk("ds_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    data_tvalid = 1'b0;
    scle_tvalid = 1'b0;
  endtask

  task automatic send_grid(input logic [15:0] g, input logic l);
    int n;
    n = 0;
    grid_tdata  = g;
    grid_tlast  = l;
    grid_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (grid_tready) break;
      n++;
      if (n > 200) begin
        chk("grid_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    grid_tvalid = 1'b0;
  endtask

  task automatic check_row(input string tag);
    logic [48:0] got;
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_nbeats"}, q_beat.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < q_beat.size()) ? q_beat[i] : '0;
      chk($sformatf("%s_b%0d", tag, i), got, exp_q[i]);
    end
  endtask

  initial begin
    logic pat [6];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    // reset state, with data and scale both offered
    data_tvalid = 1'b1;
    scle_tvalid = 1'b1;
    #12;
    chk("rst_data_rdy", data_tready, 0);
    chk("rst_scle_rdy", scle_tready, 0);
    chk("rst_grid_rdy", grid_tready, 0);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_rows", rows_done, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    data_tvalid = 1'b0;
    scle_tvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: basic row of 4
    start_test();
    cfg_grid_len = 8'd4;
    fork
      send_ds(16'h0011, 1'b0, 16'h0100);
      begin
        for (int i = 1; i <= 4; i++) send_grid(16'(i), i == 4);
      end
    join
    for (int i = 1; i <= 4; i++)
      exp_q.push_back(bt(1'b0, 16'h0100, 16'(i), 16'h0011));
    check_row("t1");
    chk("t1_rows", rows_done, 1);
    chk("t1_err", err, 0);
    chk("t1_busy", busy, 0);

    // 2: two samples, one bubble between rows
    start_test();
    cfg_grid_len = 8'd3;
    fork
      begin
        send_ds(16'h0021, 1'b0, 16'h0201);
        send_ds(16'h0022, 1'b1, 16'h0202);
      end
      begin
        for (int i = 1; i <= 6; i++) send_grid(16'(i), (i == 3) || (i == 6));
      end
    join
    for (int i = 1; i <= 3; i++)
      exp_q.push_back(bt(1'b0, 16'h0201, 16'(i), 16'h0021));
    for (int i = 4; i <= 6; i++)
      exp_q.push_back(bt(i == 6, 16'h0202, 16'(i), 16'h0022));
    check_row("t2");
    chk("t2_rows", rows_done, 3);
    if (q_cyc.size() == 6) begin
      chk("t2_gap01", q_cyc[1] - q_cyc[0], 1);
      chk("t2_gap23", q_cyc[3] - q_cyc[2], 2);
      chk("t2_gap45", q_cyc[5] - q_cyc[4], 1);
    end else begin
      chk("t2_cyc_n", q_cyc.size(), 6);
    end

    // 3: early tlast, then a clean row
    start_test();
    cfg_grid_len = 8'd4;
    fork
      send_ds(16'h0044, 1'b0, 16'h0400);
      begin
        send_grid(16'h0009, 1'b0);
        chk("t3_err_pre", err, 0);
        send_grid(16'h000a, 1'b1);
        chk("t3_err_set", err, 1);
      end
    join
    fork
      send_ds(16'h0055, 1'b1, 16'h0500);
      begin
        for (int i = 1; i <= 4; i++) send_grid(16'(i), i == 4);
      end
    join
    exp_q.push_back(bt(1'b0, 16'h0400, 16'h0009, 16'h0044));
    exp_q.push_back(bt(1'b0, 16'h0400, 16'h000a, 16'h0044));
    for (int i = 1; i <= 4; i++)
      exp_q.push_back(bt(i == 4, 16'h0500, 16'(i), 16'h0055));
    check_row("t3");
    chk("t3_rows", rows_done, 5);
    chk("t3_err_sticky", err, 1);
    err_clear = 1'b1;
    @(posedge clk);
    #1;
    err_clear = 1'b0;
    chk("t3_err_clr", err, 0);

    // 3b: length reached without tlast, err_clear held high (set wins)
    start_test();
    cfg_grid_len = 8'd2;
    err_clear = 1'b1;
    fork
      send_ds(16'h0033, 1'b0, 16'h0300);
      begin
        send_grid(16'h0007, 1'b0);
        send_grid(16'h0008, 1'b0);
      end
    join
    chk("t3b_err_win", err, 1);
    err_clear = 1'b0;
    exp_q.push_back(bt(1'b0, 16'h0300, 16'h0007, 16'h0033));
    exp_q.push_back(bt(1'b0, 16'h0300, 16'h0008, 16'h0033));
    check_row("t3b");
    chk("t3b_rows", rows_done, 6);
    err_clear = 1'b1;
    @(posedge clk);
    #1;
    err_clear = 1'b0;

    // 4: output backpressure pattern during a row of 5
    start_test();
    cfg_grid_len = 8'd5;
    fork
      send_ds(16'h0088, 1'b0, 16'h0800);
      begin
        for (int i = 1; i <= 5; i++) send_grid(16'(i), i == 5);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
          m_tready = pat[i];
          @(posedge clk);
          #1;
        end
        m_tready = 1'b1;
      end
    join
    for (int i = 1; i <= 5; i++)
      exp_q.push_back(bt(1'b0, 16'h0800, 16'(i), 16'h0088));
    check_row("t4");
    chk("t4_rows", rows_done, 7);
    chk("t4_err", err, 0);

    // 5: scale alone, data arrives three cycles later
    start_test();
    cfg_grid_len = 8'd1;
    scle_tdata  = 16'h0600;
    scle_tvalid = 1'b1;
    data_tdata  = 16'h0066;
    data_tlast  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("t5_drdy_%0d", i), data_tready, 0);
      chk($sformatf("t5_srdy_%0d", i), scle_tready, 0);
      @(posedge clk);
      #1;
    end
    data_tvalid = 1'b1;
    @(negedge clk);
    chk("t5_drdy_go", data_tready, 1);
    chk("t5_srdy_go", scle_tready, 1);
    @(posedge clk);
    #1;
    data_tvalid = 1'b0;
    scle_tvalid = 1'b0;
    send_grid(16'h0abc, 1'b1);
    exp_q.push_back(bt(1'b1, 16'h0600, 16'h0abc, 16'h0066));
    check_row("t5");
    chk("t5_rows", rows_done, 8);
    chk("t5_err", err, 0);

    // 6: asynchronous reset mid-row, then a fresh row
    start_test();
    cfg_grid_len = 8'd4;
    fork
      send_ds(16'h0077, 1'b0, 16'h0700);
      begin
        send_grid(16'h0001, 1'b0);
        send_grid(16'h0002, 1'b0);
      end
    join
    chk("t6_pre_tvalid", m_tvalid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_tvalid", m_tvalid, 0);
    chk("t6_rst_grdy", grid_tready, 0);
    chk("t6_rst_rows", rows_done, 0);
    chk("t6_rst_busy", busy, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start_test();
    cfg_grid_len = 8'd2;
    fork
      send_ds(16'h0022, 1'b1, 16'h0200);
      begin
        send_grid(16'h0005, 1'b0);
        send_grid(16'h0006, 1'b1);
      end
    join
    exp_q.push_back(bt(1'b0, 16'h0200, 16'h0005, 16'h0022));
    exp_q.push_back(bt(1'b1, 16'h0200, 16'h0006, 16'h0022));
    check_row("t6");
    chk("t6_rows", rows_done, 1);
    chk("t6_err", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
